// File: rtl/huffman_pkg.sv
// -----------------------------------------------------------------------------
// huffman_pkg
// Shared definitions for the Huffman frame sequencer: symbol width, legal
// symbol range, statistics counter width, controller state encoding and a
// saturating increment used by the optional statistics counters.
// -----------------------------------------------------------------------------
package huffman_pkg;

    localparam int SYM_W   = 4;   // width of one Huffman input symbol
    localparam int SYM_MAX = 9;   // largest legal symbol value (not enforced)
    localparam int STAT_W  = 16;  // width of the statistics counters

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,  // accepting and storing the upstream frame
        ST_DRAIN   = 3'd1,  // frame overflowed: swallow symbols up to sym_last
        ST_BURST   = 3'd2,  // replaying the stored frame to the datapath
        ST_WAIT    = 3'd3,  // waiting for the datapath to finish the frame
        ST_RECOV   = 3'd4   // holding the datapath in reset after a timeout
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hfc_frame_buf.sv
// -----------------------------------------------------------------------------
// hfc_frame_buf
// DEPTH x SYM_W simple dual-port frame buffer with a registered read port.
// The read register returns zero whenever no read is requested, so it can
// drive the datapath symbol bus directly and idle at zero between bursts.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write symbol
//   rd_en    in   read request; data appears on rd_data one cycle later
//   rd_addr  in   read address
//   rd_data  out  registered read symbol (0 when the previous cycle had no read)
// -----------------------------------------------------------------------------
module hfc_frame_buf
    import huffman_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SYM_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [SYM_W-1:0] rd_data
);

    logic [SYM_W-1:0] mem [DEPTH];
    logic [SYM_W-1:0] rd_data_q;

    // Storage array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/huffman_frame_ctrl.sv
// -----------------------------------------------------------------------------
// huffman_frame_ctrl
// Frame sequencer in front of huffman_top. Buffers one upstream frame of
// 4-bit symbols, replays it as a gapless burst framed by hc_start /
// hc_start_done, waits for hc_output_done with a watchdog and, on expiry,
// pulses the datapath reset for two cycles before accepting the next frame.
//
// Optional feature macro: HFC_STATS_EN
//   defined   : frame_cnt counts completed frames, serial_cycles holds the
//               hc_output_start..hc_output_done span of the last frame
//   undefined : both statistics outputs are tied to 0
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   sym_valid/sym_ready          upstream handshake
//   sym_data, sym_last           upstream symbol and end-of-frame marker
//   hc_rst_n                     datapath reset (active-low)
//   hc_start, hc_start_done      burst framing pulses to the datapath
//   hc_data                      burst symbol to the datapath (0 when idle)
//   hc_output_start/done         datapath progress, honoured only in WAIT
//   busy                         high in BURST, WAIT and RECOV
//   frame_done                   one-cycle pulse per completed frame
//   err_clr                      clears the sticky error flags
//   err_trunc, err_timeout       sticky overflow / watchdog flags
//   frame_cnt, serial_cycles     statistics (see macro above)
// -----------------------------------------------------------------------------
module huffman_frame_ctrl
    import huffman_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int AW          = $clog2(DEPTH),
    parameter int TIMEOUT_CYC = 4096,
    parameter int TW          = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [SYM_W-1:0]  sym_data,
    input  logic              sym_last,
    output logic              hc_rst_n,
    output logic              hc_start,
    output logic              hc_start_done,
    output logic [SYM_W-1:0]  hc_data,
    input  logic              hc_output_start,
    input  logic              hc_output_done,
    output logic              busy,
    output logic              frame_done,
    input  logic              err_clr,
    output logic              err_trunc,
    output logic              err_timeout,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] serial_cycles
);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_q, wr_d;             // next buffer write slot
    logic [AW-1:0]   last_idx_q, last_idx_d; // index of final symbol (len-1)
    logic [AW-1:0]   rd_idx_q, rd_idx_d;     // burst read pointer
    logic [TW-1:0]   wd_q, wd_d;             // watchdog
    logic            recov_q, recov_d;       // second RECOV cycle marker
    logic            sym_ready_q, sym_ready_d;
    logic            hc_rst_n_q, hc_rst_n_d;
    logic            hc_start_q, hc_start_d;
    logic            hc_start_done_q, hc_start_done_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            err_trunc_q, err_trunc_d;
    logic            err_timeout_q, err_timeout_d;
    logic            set_trunc, set_timeout;
    logic            accept;
    logic            buf_wr_en;
    logic            buf_rd_en;

    // Handshake uses the registered ready so nothing is accepted while
    // rst_n is low, even though the state already reads COLLECT.
    assign accept    = sym_valid & sym_ready_q;
    assign buf_wr_en = accept && (state_q == ST_COLLECT);
    // Reading starts in the hc_start cycle so buf[0] is on hc_data the
    // cycle after, and continues back-to-back to the last symbol.
    assign buf_rd_en = (state_q == ST_BURST);

    hfc_frame_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_q),
        .wr_data (sym_data),
        .rd_en   (buf_rd_en),
        .rd_addr (rd_idx_q),
        .rd_data (hc_data)
    );

    always_comb begin
        state_d         = state_q;
        wr_d            = wr_q;
        last_idx_d      = last_idx_q;
        rd_idx_d        = rd_idx_q;
        wd_d            = wd_q;
        recov_d         = 1'b0;
        hc_rst_n_d      = 1'b1;
        hc_start_d      = 1'b0;
        hc_start_done_d = 1'b0;
        frame_done_d    = 1'b0;
        set_trunc       = 1'b0;
        set_timeout     = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    wr_d = wr_q + 1'b1;
                    if (sym_last) begin
                        last_idx_d = wr_q;
                        rd_idx_d   = '0;
                        hc_start_d = 1'b1;
                        state_d    = ST_BURST;
                    end else if (wr_q == AW'(DEPTH - 1)) begin
                        // Buffer full without end of frame: keep DEPTH symbols.
                        last_idx_d = wr_q;
                        set_trunc  = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (accept && sym_last) begin
                    rd_idx_d   = '0;
                    hc_start_d = 1'b1;
                    state_d    = ST_BURST;
                end
            end

            ST_BURST: begin
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_idx_q == last_idx_q) begin
                    // The read issued now lands with the start_done flag.
                    hc_start_done_d = 1'b1;
                    wd_d            = '0;
                    state_d         = ST_WAIT;
                end
            end

            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                // Done is checked first so a same-cycle expiry is not an error.
                if (hc_output_done) begin
                    frame_done_d = 1'b1;
                    wr_d         = '0;
                    state_d      = ST_COLLECT;
                end else if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                    set_timeout = 1'b1;
                    hc_rst_n_d  = 1'b0;
                    state_d     = ST_RECOV;
                end
            end

            ST_RECOV: begin
                if (recov_q) begin
                    wr_d    = '0;
                    state_d = ST_COLLECT;
                end else begin
                    recov_d    = 1'b1;
                    hc_rst_n_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        sym_ready_d   = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
        busy_d        = (state_d == ST_BURST) || (state_d == ST_WAIT) ||
                        (state_d == ST_RECOV);
        // A new error in the same cycle as err_clr survives the clear.
        err_trunc_d   = set_trunc   | (err_trunc_q   & ~err_clr);
        err_timeout_d = set_timeout | (err_timeout_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_COLLECT;
            wr_q            <= '0;
            last_idx_q      <= '0;
            rd_idx_q        <= '0;
            wd_q            <= '0;
            recov_q         <= 1'b0;
            sym_ready_q     <= 1'b0;
            hc_rst_n_q      <= 1'b0;
            hc_start_q      <= 1'b0;
            hc_start_done_q <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            err_trunc_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_q            <= wr_d;
            last_idx_q      <= last_idx_d;
            rd_idx_q        <= rd_idx_d;
            wd_q            <= wd_d;
            recov_q         <= recov_d;
            sym_ready_q     <= sym_ready_d;
            hc_rst_n_q      <= hc_rst_n_d;
            hc_start_q      <= hc_start_d;
            hc_start_done_q <= hc_start_done_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            err_trunc_q     <= err_trunc_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign sym_ready     = sym_ready_q;
    assign hc_rst_n      = hc_rst_n_q;
    assign hc_start      = hc_start_q;
    assign hc_start_done = hc_start_done_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign err_trunc     = err_trunc_q;
    assign err_timeout   = err_timeout_q;

`ifdef HFC_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [STAT_W-1:0] serial_q, serial_d;
    logic [STAT_W-1:0] meas_q, meas_d;       // cycles since hc_output_start
    logic              meas_act_q, meas_act_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        serial_d    = serial_q;
        meas_d      = meas_q;
        meas_act_d  = meas_act_q;

        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if (state_q == ST_WAIT) begin
            if (hc_output_done) begin
                // Start and done together is a zero-length span.
                serial_d   = (meas_act_q && !hc_output_start) ? meas_q : '0;
                meas_act_d = 1'b0;
            end else if (hc_output_start) begin
                // Start cycle counts as the first cycle of the span.
                meas_d     = {{(STAT_W-1){1'b0}}, 1'b1};
                meas_act_d = 1'b1;
            end else if (meas_act_q) begin
                meas_d = sat_inc(meas_q);
            end
        end else begin
            meas_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            serial_q    <= '0;
            meas_q      <= '0;
            meas_act_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            serial_q    <= serial_d;
            meas_q      <= meas_d;
            meas_act_q  <= meas_act_d;
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign serial_cycles = serial_q;
`else
    // hc_output_start only feeds the statistics; keep it visibly consumed.
    logic unused_stats_in;
    assign unused_stats_in = hc_output_start;
    assign frame_cnt       = '0;
    assign serial_cycles   = '0;
`endif

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_huffman_frame_ctrl
// Randomized bench for huffman_frame_ctrl. The stimulus side builds each
// frame, derives the expected burst (truncated to DEPTH) and queues it; a
// monitor compares every burst cycle against that queue and checks that the
// symbol bus idles at zero between bursts. Control responses (frame_done,
// errors, watchdog recovery, statistics) are checked by the stimulus flow.
// -----------------------------------------------------------------------------
module tb_huffman_frame_ctrl;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_data;
    logic        sym_last;
    logic        hc_rst_n;
    logic        hc_start;
    logic        hc_start_done;
    logic [3:0]  hc_data;
    logic        hc_output_start;
    logic        hc_output_done;
    logic        busy;
    logic        frame_done;
    logic        err_clr;
    logic        err_trunc;
    logic        err_timeout;
    logic [15:0] frame_cnt;
    logic [15:0] serial_cycles;

    always #5 clk = ~clk;

    huffman_frame_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT),
        .TW          (13)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_data        (sym_data),
        .sym_last        (sym_last),
        .hc_rst_n        (hc_rst_n),
        .hc_start        (hc_start),
        .hc_start_done   (hc_start_done),
        .hc_data         (hc_data),
        .hc_output_start (hc_output_start),
        .hc_output_done  (hc_output_done),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_clr         (err_clr),
        .err_trunc       (err_trunc),
        .err_timeout     (err_timeout),
        .frame_cnt       (frame_cnt),
        .serial_cycles   (serial_cycles)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Scoreboard entries: {is_start_cycle, is_last_symbol, symbol}.
    logic [5:0] exp_q [$];
    bit         in_burst      = 1'b0;
    bit         mon_en        = 1'b1;
    int         exp_start_cyc = 0;
    int         last_sd_cyc   = 0;
    int         frame_model   = 0;
    logic [3:0] fsyms [0:79];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [5:0] item;
        if (!mon_en) begin
            in_burst = 1'b0;
        end else if (hc_start || in_burst) begin
            if (exp_q.size() == 0) begin
                chk("burst_unexpected", {hc_start, hc_start_done, hc_data}, 6'h00);
                in_burst = 1'b0;
            end else begin
                item = exp_q.pop_front();
                chk("burst_item", {hc_start, hc_start_done, hc_data}, item);
                if (item[5]) begin
                    chk("start_latency", cyc, exp_start_cyc);
                    chk("ready_low_burst", sym_ready, 1'b0);
                    chk("busy_burst", busy, 1'b1);
                end
                if (item[4]) last_sd_cyc = cyc;
                in_burst = !item[4];
            end
        end else begin
            chk("idle_bus", {hc_start_done, hc_data}, 5'h00);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input int n, input int maxgap);
        int g;
        int m;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                @(negedge clk);
                sym_valid = 1'b0;
                sym_last  = 1'b0;
            end
            @(negedge clk);
            sym_valid = 1'b1;
            sym_data  = fsyms[i];
            sym_last  = (i == n - 1);
            g = 0;
            while (!sym_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            chk("ready_wait_bound", (g < 200), 1'b1);
            if (i == n - 1) begin
                m = (n > DEPTH) ? DEPTH : n;
                exp_q.push_back(6'b100000);
                for (int j = 0; j < m; j++) exp_q.push_back({1'b0, (j == m - 1), fsyms[j]});
                exp_start_cyc = cyc + 1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic wait_burst();
        int g = 0;
        while ((exp_q.size() != 0 || in_burst) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("burst_end_bound", (g < 2000), 1'b1);
    endtask

    task automatic do_output(input int span);
        chk("ready_low_wait", sym_ready, 1'b0);
        @(negedge clk);
        hc_output_start = 1'b1;
        @(negedge clk);
        hc_output_start = 1'b0;
        repeat (span - 1) @(negedge clk);
        hc_output_done = 1'b1;
        @(negedge clk);
        hc_output_done = 1'b0;
        frame_model++;
        chk("frame_done", frame_done, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("ready_after", sym_ready, 1'b1);
`ifdef HFC_STATS_EN
        chk("frame_cnt", frame_cnt, frame_model & 16'hFFFF);
        chk("serial_cycles", serial_cycles, span);
`else
        chk("frame_cnt_off", frame_cnt, 16'h0);
        chk("serial_off", serial_cycles, 16'h0);
`endif
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1'b0);
    endtask

    task automatic rand_syms(input int n);
        for (int i = 0; i < n; i++) fsyms[i] = 4'($urandom_range(15, 0));
    endtask

    // ---------------- main flow ----------------
    initial begin
        int s;
        int r;
        int g;
        rst_n = 1'b0; sym_valid = 1'b0; sym_data = '0; sym_last = 1'b0;
        hc_output_start = 1'b0; hc_output_done = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", sym_ready, 1'b0);
        chk("rst_hc_rst_n", hc_rst_n, 1'b0);
        chk("rst_outputs", {hc_start, hc_start_done, hc_data, busy, frame_done, err_trunc, err_timeout}, 10'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hc_rst_n", hc_rst_n, 1'b1);
        chk("post_rst_ready", sym_ready, 1'b1);

        // Fixed frame, no gaps, then with random gaps.
        fsyms[0] = 4'd3; fsyms[1] = 4'd3; fsyms[2] = 4'd7; fsyms[3] = 4'd0;
        send_frame(4, 0); wait_burst(); do_output(10);
        send_frame(4, 3); wait_burst(); do_output(20);

        // Single-symbol frame.
        fsyms[0] = 4'd9;
        send_frame(1, 0); wait_burst(); do_output(5);

        // Datapath handshakes outside WAIT are ignored.
        @(negedge clk); hc_output_done = 1'b1; hc_output_start = 1'b1;
        @(negedge clk); hc_output_done = 1'b0; hc_output_start = 1'b0;
        chk("ignored_done", frame_done, 1'b0);
        chk("ignored_ready", sym_ready, 1'b1);

        // Random frames of random length.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(DEPTH, 1);
            rand_syms(n);
            send_frame(n, 2); wait_burst(); do_output($urandom_range(30, 1));
        end

        // Oversized frame: first DEPTH symbols replayed, rest dropped.
        rand_syms(70);
        send_frame(70, 1); wait_burst();
        chk("err_trunc_set", err_trunc, 1'b1);
        do_output(3);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_trunc_clr", err_trunc, 1'b0);
        rand_syms(5);
        send_frame(5, 1); wait_burst(); do_output(7);

        // Watchdog expiry and datapath recovery.
        rand_syms(3);
        send_frame(3, 0); wait_burst();
        s = last_sd_cyc;
        g = 0;
        while (hc_rst_n && g < 6000) begin
            @(negedge clk);
            g++;
        end
        r = cyc;
        chk("timeout_bound", (g < 6000), 1'b1);
        chk("timeout_delay", r - s, TIMEOUT);
        chk("err_timeout_set", err_timeout, 1'b1);
        chk("timeout_no_done", frame_done, 1'b0);
        @(negedge clk);
        chk("recov_low2", hc_rst_n, 1'b0);
        @(negedge clk);
        chk("recov_release", hc_rst_n, 1'b1);
        chk("recov_ready", sym_ready, 1'b1);
        chk("recov_busy", busy, 1'b0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_timeout_clr", err_timeout, 1'b0);

        // Done in the exact expiry cycle wins.
        rand_syms(2);
        send_frame(2, 0); wait_burst();
        s = last_sd_cyc;
        while (cyc < s + TIMEOUT - 1) @(negedge clk);
        hc_output_done = 1'b1;
        @(negedge clk);
        hc_output_done = 1'b0;
        frame_model++;
        chk("race_frame_done", frame_done, 1'b1);
        chk("race_no_timeout", err_timeout, 1'b0);
        chk("race_hc_rst_n", hc_rst_n, 1'b1);
`ifdef HFC_STATS_EN
        chk("race_frame_cnt", frame_cnt, frame_model & 16'hFFFF);
`endif
        @(negedge clk);

        // Reset in the middle of a burst.
        rand_syms(30);
        send_frame(30, 0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {hc_start, hc_start_done, hc_data, busy, frame_done, err_trunc, err_timeout}, 10'h0);
        chk("midrst_ready", sym_ready, 1'b0);
        chk("midrst_hc_rst_n", hc_rst_n, 1'b0);
        chk("midrst_stats", {frame_cnt, serial_cycles}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        frame_model = 0;
        @(negedge clk);
        rand_syms(6);
        send_frame(6, 1); wait_burst(); do_output(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
